// File: rtl/hazard_controller_if.sv
// Signal bundle between the ID-stage decode/datapath and the hazard controller.
// The master drives decoded ID fields and datapath status; the slave returns enables, flushes and counters.
interface hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [3:0]       id_rn;
    logic [3:0]       id_rm;
    logic             id_use_rn;
    logic             id_use_rm;
    logic [3:0]       id_rd;
    logic             id_wr_rd;
    logic             id_is_load;
    logic             id_is_store;
    logic             id_sets_flags;
    logic             id_reads_flags;
    logic             ex_branch_taken;
    logic             mem_ready;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             stall;
    logic             mem_wait;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd, id_wr_rd,
               id_is_load, id_is_store, id_sets_flags, id_reads_flags,
               ex_branch_taken, mem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, stall, mem_wait, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd, id_wr_rd,
               id_is_load, id_is_store, id_sets_flags, id_reads_flags,
               ex_branch_taken, mem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, stall, mem_wait, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller for the five-stage core: load-use, flag and branch hazards,
// data-memory wait freeze, plus saturating stall/flush event counters.
module hazard_controller #(
    parameter int CNT_W = 16
) (
    input logic                clk,
    input logic                rst_n,
    hazard_controller_if.slave bus
);

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] rd;
        logic       wr_rd;
        logic       is_load;
        logic       sets_flags;
        logic       is_mem;
    } ex_shadow_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    ex_shadow_t       ex_q, ex_d;
    logic             mem_valid_q;
    logic             mem_is_mem_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic freeze;
    logic load_use;
    logic flag_hazard;
    logic id_stall;
    logic bubble;

    // Shadow state cannot advance while the instruction in MEM waits on data memory.
    assign freeze = mem_valid_q & mem_is_mem_q & ~bus.mem_ready;

    assign load_use = bus.id_valid & ex_q.valid & ex_q.is_load & ex_q.wr_rd &
                      ((bus.id_use_rn & (bus.id_rn == ex_q.rd)) |
                       (bus.id_use_rm & (bus.id_rm == ex_q.rd)));

    assign flag_hazard = bus.id_valid & bus.id_reads_flags & ex_q.valid & ex_q.sets_flags;

    // A taken branch squashes the stalled instruction, so it never counts as a stall.
    assign id_stall = (load_use | flag_hazard) & ~bus.ex_branch_taken;
    assign bubble   = id_stall | bus.ex_branch_taken;

    always_comb begin
        // NOTE: every output gets a default first so no path through the if-chain can infer a latch.
        bus.pc_en      = 1'b1;
        bus.ifid_en    = 1'b1;
        bus.idex_en    = 1'b1;
        bus.exmem_en   = 1'b1;
        bus.memwb_en   = 1'b1;
        bus.ifid_flush = 1'b0;
        bus.idex_flush = 1'b0;
        bus.stall      = 1'b0;

        if (rst_n) begin
            if (freeze) begin
                bus.pc_en    = 1'b0;
                bus.ifid_en  = 1'b0;
                bus.idex_en  = 1'b0;
                bus.exmem_en = 1'b0;
                bus.memwb_en = 1'b0;
            end else if (bus.ex_branch_taken) begin
                bus.ifid_flush = 1'b1;
                bus.idex_flush = 1'b1;
            end else if (id_stall) begin
                bus.pc_en      = 1'b0;
                bus.ifid_en    = 1'b0;
                bus.idex_flush = 1'b1;
                bus.stall      = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:      if (freeze) state_d = MEM_WAIT;
            MEM_WAIT: if (bus.mem_ready) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_comb begin
        ex_d.valid      = bus.id_valid;
        ex_d.rd         = bus.id_rd;
        ex_d.wr_rd      = bus.id_wr_rd;
        ex_d.is_load    = bus.id_is_load;
        ex_d.sets_flags = bus.id_sets_flags;
        ex_d.is_mem     = bus.id_is_load | bus.id_is_store;
        if (bubble) ex_d = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q         <= '0;
            mem_valid_q  <= 1'b0;
            mem_is_mem_q <= 1'b0;
        end else if (!freeze) begin
            ex_q         <= ex_d;
            mem_valid_q  <= ex_q.valid;
            mem_is_mem_q <= ex_q.is_mem;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (!freeze) begin
            if (id_stall && stall_cnt_q != CNT_MAX)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (bus.ex_branch_taken && flush_cnt_q != CNT_MAX)
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign bus.mem_wait  = (state_q == MEM_WAIT);
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

endmodule
